// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: state codes, opcodes,
// ALU-operation codes and datapath mux select values.
package mc_ctrl_pkg;

  typedef logic [3:0] state_t;

  // State encodings; state_dbg exposes these values directly.
  localparam state_t StFetch   = 4'd0;
  localparam state_t StDecode  = 4'd1;
  localparam state_t StMemAdr  = 4'd2;
  localparam state_t StMemRd   = 4'd3;
  localparam state_t StMemWb   = 4'd4;
  localparam state_t StMemWr   = 4'd5;
  localparam state_t StRtypeEx = 4'd6;
  localparam state_t StRtypeWb = 4'd7;
  localparam state_t StAddiEx  = 4'd8;
  localparam state_t StAddiWb  = 4'd9;
  localparam state_t StBranch  = 4'd10;
  localparam state_t StJump    = 4'd11;

  // Instruction opcodes (instruction[31:26]).
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // ALU-control opcodes, shared with alucontrol.
  localparam logic [6:0] AluOpAdd   = 7'b0000000;
  localparam logic [6:0] AluOpSub   = 7'b0000001;
  localparam logic [6:0] AluOpFunct = 7'b0000010;

  // ALU B-operand select.
  localparam logic [1:0] AluBReg      = 2'b00;
  localparam logic [1:0] AluBFour     = 2'b01;
  localparam logic [1:0] AluBImm      = 2'b10;
  localparam logic [1:0] AluBImmShift = 2'b11;

  // Next-PC select.
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: registered state plus combinational output decode.
// Define MC_CTRL_JUMP_EN to support the J instruction; otherwise J decodes as illegal.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic [6:0]          ALUOP,
  output logic                illegal_op,
  output logic [3:0]          state_dbg
);

  state_t state_q, state_d;

  logic op_rtype, op_lw, op_sw, op_beq, op_addi, op_legal;

  assign op_rtype = (opcode == OPCODE_W'(OpRtype));
  assign op_lw    = (opcode == OPCODE_W'(OpLw));
  assign op_sw    = (opcode == OPCODE_W'(OpSw));
  assign op_beq   = (opcode == OPCODE_W'(OpBeq));
  assign op_addi  = (opcode == OPCODE_W'(OpAddi));

`ifdef MC_CTRL_JUMP_EN
  logic op_j;
  assign op_j     = (opcode == OPCODE_W'(OpJ));
  assign op_legal = op_rtype | op_lw | op_sw | op_beq | op_addi | op_j;
`else
  assign op_legal = op_rtype | op_lw | op_sw | op_beq | op_addi;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        if (op_lw || op_sw)  state_d = StMemAdr;
        else if (op_rtype)   state_d = StRtypeEx;
        else if (op_addi)    state_d = StAddiEx;
        else if (op_beq)     state_d = StBranch;
`ifdef MC_CTRL_JUMP_EN
        else if (op_j)       state_d = StJump;
`endif
        else                 state_d = StFetch;
      end
      StMemAdr: begin
        if (op_lw)       state_d = StMemRd;
        else if (op_sw)  state_d = StMemWr;
        else             state_d = StFetch;
      end
      StMemRd: begin
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb:   state_d = StFetch;
      StMemWr: begin
        if (mem_ready) state_d = StFetch;
      end
      StRtypeEx: state_d = StRtypeWb;
      StRtypeWb: state_d = StFetch;
      StAddiEx:  state_d = StAddiWb;
      StAddiWb:  state_d = StFetch;
      StBranch:  state_d = StFetch;
`ifdef MC_CTRL_JUMP_EN
      StJump:    state_d = StFetch;
`endif
      // Unused encodings recover to FETCH.
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode: Moore per state, except the FETCH completion strobes follow mem_ready.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = AluBReg;
    PCSource    = PcSrcAlu;
    ALUOP       = AluOpAdd;
    illegal_op  = 1'b0;
    case (state_q)
      StFetch: begin
        MemRead  = 1'b1;
        ALUSrcB  = AluBFour;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
      end
      StDecode: begin
        ALUSrcB    = AluBImmShift;
        illegal_op = ~op_legal;
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = AluBImm;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StRtypeEx: begin
        ALUSrcA = 1'b1;
        ALUOP   = AluOpFunct;
      end
      StRtypeWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = AluBImm;
      end
      StAddiWb: begin
        RegWrite = 1'b1;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOP       = AluOpSub;
        PCWriteCond = 1'b1;
        PCSource    = PcSrcAluOut;
      end
`ifdef MC_CTRL_JUMP_EN
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = PcSrcJump;
      end
`endif
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes hand-computed per-cycle
// expectations, a monitor pops and compares them on the falling clock edge.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, PCSource;
  logic [6:0] ALUOP;
  logic [3:0] state_dbg;

  multicycle_control #(.OPCODE_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .ALUOP       (ALUOP),
    .illegal_op  (illegal_op),
    .state_dbg   (state_dbg)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic [6:0] aluop;
    logic       ill;
  } obs_t;

  // Hand-derived expected output vectors (state, strobes, selects, ALUOP, illegal).
  //                                st     pcw pcwc iord mrd mwr m2r irw rdst rw asa asb    pcs    aluop ill
  localparam obs_t EFetchWait = '{4'd0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 7'd0, 0};
  localparam obs_t EFetchGo   = '{4'd0,  1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 7'd0, 0};
  localparam obs_t EDecode    = '{4'd1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 7'd0, 0};
  localparam obs_t EDecodeIll = '{4'd1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 7'd0, 1};
  localparam obs_t EMemAdr    = '{4'd2,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 7'd0, 0};
  localparam obs_t EMemRd     = '{4'd3,  0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 7'd0, 0};
  localparam obs_t EMemWb     = '{4'd4,  0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 7'd0, 0};
  localparam obs_t EMemWr     = '{4'd5,  0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 7'd0, 0};
  localparam obs_t ERtypeEx   = '{4'd6,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 7'd2, 0};
  localparam obs_t ERtypeWb   = '{4'd7,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 7'd0, 0};
  localparam obs_t EAddiEx    = '{4'd8,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 7'd0, 0};
  localparam obs_t EAddiWb    = '{4'd9,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 7'd0, 0};
  localparam obs_t EBranch    = '{4'd10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 7'd1, 0};
  localparam obs_t EJump      = '{4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 7'd0, 0};

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpBad  = 6'b111111;

  obs_t  obs;
  obs_t  exp_q[$];
  string name_q[$];
  int    checks;
  int    errors;

  assign obs = '{state_dbg, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                 RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOP, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per cycle, sampled mid-cycle.
  initial begin
    obs_t  e;
    string nm;
    checks = 0;
    errors = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", nm, obs, e);
        end
        if (MemRead && MemWrite) begin
          errors++;
          $display("FAIL %s_rdwr_excl: got MemRead=1 MemWrite=1 required not both", nm);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the output expected during that cycle.
  task automatic step(input logic [5:0] op, input logic mr, input obs_t e, input string nm);
    opcode    = op;
    mem_ready = mr;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wait_cycles;
    rst_n     = 1'b0;
    opcode    = OpR;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset: FETCH outputs with mem_ready gating still applied.
    step(OpR, 1'b0, EFetchWait, "reset_fetch_mr0");
    step(OpR, 1'b1, EFetchGo,   "reset_fetch_mr1");
    rst_n = 1'b1;

    // LW, mem_ready always high: 5 cycles.
    step(OpLw, 1'b1, EFetchGo, "lw_fetch");
    step(OpLw, 1'b1, EDecode,  "lw_decode");
    step(OpLw, 1'b1, EMemAdr,  "lw_memadr");
    step(OpLw, 1'b1, EMemRd,   "lw_memrd");
    step(OpLw, 1'b1, EMemWb,   "lw_memwb");

    // R-type with three FETCH wait cycles.
    step(OpR, 1'b0, EFetchWait, "r_fetch_wait1");
    step(OpR, 1'b0, EFetchWait, "r_fetch_wait2");
    step(OpR, 1'b0, EFetchWait, "r_fetch_wait3");
    step(OpR, 1'b1, EFetchGo,   "r_fetch_go");
    step(OpR, 1'b0, EDecode,    "r_decode");
    step(OpR, 1'b0, ERtypeEx,   "r_ex");
    step(OpR, 1'b0, ERtypeWb,   "r_wb");

    // ADDI, mem_ready low outside memory states must not matter.
    step(OpAddi, 1'b1, EFetchGo, "addi_fetch");
    step(OpAddi, 1'b0, EDecode,  "addi_decode");
    step(OpAddi, 1'b0, EAddiEx,  "addi_ex");
    step(OpAddi, 1'b0, EAddiWb,  "addi_wb");

    // LW with one MEMRD wait.
    step(OpLw, 1'b1, EFetchGo, "lw2_fetch");
    step(OpLw, 1'b0, EDecode,  "lw2_decode");
    step(OpLw, 1'b0, EMemAdr,  "lw2_memadr");
    step(OpLw, 1'b0, EMemRd,   "lw2_memrd_wait");
    step(OpLw, 1'b1, EMemRd,   "lw2_memrd_go");
    step(OpLw, 1'b0, EMemWb,   "lw2_memwb");

    // SW with one MEMWR wait.
    step(OpSw, 1'b1, EFetchGo, "sw_fetch");
    step(OpSw, 1'b1, EDecode,  "sw_decode");
    step(OpSw, 1'b1, EMemAdr,  "sw_memadr");
    step(OpSw, 1'b0, EMemWr,   "sw_memwr_wait");
    step(OpSw, 1'b1, EMemWr,   "sw_memwr_go");

    // BEQ: single BRANCH cycle, then back to FETCH.
    step(OpBeq, 1'b1, EFetchGo, "beq_fetch");
    step(OpBeq, 1'b1, EDecode,  "beq_decode");
    step(OpBeq, 1'b1, EBranch,  "beq_branch");
    step(OpBeq, 1'b0, EFetchWait, "beq_back_fetch");

    // Illegal opcode.
    step(OpBad, 1'b1, EFetchGo,   "bad_fetch");
    step(OpBad, 1'b1, EDecodeIll, "bad_decode");
    step(OpBad, 1'b0, EFetchWait, "bad_back_fetch");

    // J instruction.
    step(OpJ, 1'b1, EFetchGo, "j_fetch");
`ifdef MC_CTRL_JUMP_EN
    step(OpJ, 1'b1, EDecode,  "j_decode");
    step(OpJ, 1'b1, EJump,    "j_jump");
`else
    step(OpJ, 1'b1, EDecodeIll, "j_decode_illegal");
`endif
    step(OpJ, 1'b0, EFetchWait, "j_back_fetch");

    // Reset asserted while MEMWR waits: FETCH must appear with no clock edge.
    step(OpSw, 1'b1, EFetchGo, "swr_fetch");
    step(OpSw, 1'b1, EDecode,  "swr_decode");
    step(OpSw, 1'b1, EMemAdr,  "swr_memadr");
    step(OpSw, 1'b0, EMemWr,   "swr_memwr_wait");
    rst_n = 1'b0;
    step(OpSw, 1'b0, EFetchWait, "swr_async_reset");
    rst_n = 1'b1;
    step(OpBeq, 1'b0, EFetchWait, "post_reset_fetch_wait");
    step(OpBeq, 1'b1, EFetchGo,   "post_reset_fetch_go");
    step(OpBeq, 1'b1, EDecode,    "post_reset_decode");
    step(OpBeq, 1'b1, EBranch,    "post_reset_branch");

    // Drain the scoreboard with a bounded wait.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: OPCODE_W, default 6, width of the instruction opcode field [31:26].
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: opcode  input  OPCODE_W  instruction[31:26], taken from the instruction register.
REQ-005 Port: mem_ready  input  1  memory handshake; high = current read/write access completes this cycle.
REQ-006 Port: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA  output  1 each  datapath strobes/selects.
REQ-007 Port: ALUSrcB, PCSource  output  2 each  datapath mux selects.
REQ-008 Port: ALUOP  output  7  ALU-control opcode, same encoding consumed by alucontrol.
REQ-009 Port: illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-010 Port: state_dbg  output  4  current state encoding.

Function
REQ-011 Single clock domain, one active state at a time; 4-bit state register.
REQ-012 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, ADDI_EX, ADDI_WB, BRANCH, JUMP.
REQ-013 Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
REQ-014 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=ADD, PCSource=00; hold until mem_ready=1.
REQ-015 FETCH with mem_ready=1: IRWrite=1 and PCWrite=1 that same cycle (Mealy); next state DECODE. mem_ready=0: both 0, stay.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOP=ADD (branch target); next state by opcode: LW/SW->MEMADR, R->RTYPE_EX, ADDI->ADDI_EX, BEQ->BRANCH, J->JUMP.
REQ-017 DECODE with any other opcode: illegal_op=1 for that cycle, next state FETCH, no register or memory write.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOP=ADD; LW->MEMRD, SW->MEMWR.
REQ-019 MEMRD: MemRead=1, IorD=1; hold until mem_ready; then MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; then FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1; hold until mem_ready; then FETCH.
REQ-021 RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOP=FUNCT; then RTYPE_WB: RegDst=1, MemtoReg=0, RegWrite=1; then FETCH.
REQ-022 ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOP=ADD; then ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1; then FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOP=SUB, PCWriteCond=1, PCSource=01; then FETCH.
REQ-024 JUMP: PCWrite=1, PCSource=10; then FETCH.
REQ-025 Every output not listed for a state is 0; MemRead and MemWrite never both 1.
REQ-026 mem_ready ignored in states without a memory access.
REQ-027 Latency: R/ADDI/LW = 4/4/5 cycles, SW/BEQ/J = 4/3/3 cycles, each mem_ready wait adding one cycle.

Reset
REQ-028 rst_n low: state=FETCH immediately, asynchronously; illegal_op=0; outputs take FETCH values with mem_ready gating.
REQ-029 Reset mid-access (MEMRD/MEMWR waiting) abandons access; no RegWrite or PCWrite issued for it.
REQ-030 Release synchronous to clk; first post-reset edge evaluates FETCH.

Configuration
REQ-031 Macro MC_CTRL_JUMP_EN defined: J opcode handled via JUMP state per REQ-024.
REQ-032 Macro undefined: JUMP state absent, J treated as illegal per REQ-017, PCSource never 10.

Structure
REQ-033 Shared package mc_ctrl_pkg: state enum, opcode constants, ALUOP constants (ADD=7'b0000000, SUB=7'b0000001, FUNCT=7'b0000010), ALUSrcB/PCSource select constants.
REQ-034 Single module: registered next-state logic plus combinational output decoder; no sub-module.

Verification
REQ-035 LW (100011), mem_ready always 1: states FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1, MemtoReg=1 in cycle 5 only.
REQ-036 FETCH with mem_ready low 3 cycles then high: IRWrite/PCWrite=0 for 3 cycles, 1 on cycle 4, DECODE next.
REQ-037 BEQ (000100): BRANCH asserts PCWriteCond=1, ALUOP=SUB, PCSource=01 for exactly one cycle; back to FETCH.
REQ-038 opcode 111111 in DECODE: illegal_op pulses one cycle; next state FETCH; RegWrite, MemWrite stay 0.
REQ-039 rst_n low during MEMWR wait: state_dbg=FETCH without clock edge; MemWrite drops to 0 same time.
REQ-040 J (000010): with MC_CTRL_JUMP_EN PCWrite=1, PCSource=10 in JUMP; without it illegal_op=1 and PCWrite stays 0.
